// File: rtl/fpga_olvds_ser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fpga_olvds_ser: multi-lane parallel-to-serial transmitter, one bit/clk per  |
// | lane, IDLE_WORD insertion on underrun, differential pad buffers per lane.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

// Behavioural stand-in for the TMDS_33 / fast-slew differential output buffer.
module fpga_olvds_ser_obufds_tmds33 (
  input  logic d_i,
  output logic p_o,
  output logic n_o
);
  assign p_o = d_i;
  assign n_o = ~d_i;
endmodule

module fpga_olvds_ser #(
  parameter int                NLANES    = 4,
  parameter int                WIDTH     = 10,
  parameter logic [WIDTH-1:0]  IDLE_WORD = 10'b1101010100,
  parameter bit                LSB_FIRST = 1'b1,
  parameter logic [NLANES-1:0] INV_MASK  = '0
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     en,
  input  logic [NLANES*WIDTH-1:0]  s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic                     underrun,
  output logic                     frame,
  output logic [NLANES-1:0]        tx_p,
  output logic [NLANES-1:0]        tx_n
);

  localparam int                 C_CNT_W    = $clog2(WIDTH);
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(WIDTH - 1);
  localparam int                 C_FIRST    = LSB_FIRST ? 0 : WIDTH - 1;

  typedef enum logic [0:0] {
    ST_OFF = 1'b0,
    ST_RUN = 1'b1
  } state_e;

  state_e                         state_q, state_d;
  logic [C_CNT_W-1:0]             cnt_q, cnt_d;
  logic [NLANES-1:0][WIDTH-1:0]   shift_q, shift_d;
  logic [NLANES-1:0]              ser_q, ser_d;
  logic                           frame_q, frame_d;
  logic                           underrun_q, underrun_d;
  logic                           slot;
  logic [WIDTH-1:0]               word;

  // Move the next bit to transmit into the C_FIRST position.
  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    if (LSB_FIRST) return {1'b0, w[WIDTH-1:1]};
    else           return {w[WIDTH-2:0], 1'b0};
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    ser_d      = ser_q;
    frame_d    = 1'b0;
    underrun_d = 1'b0;
    s_ready    = 1'b0;
    word       = '0;
    slot       = (state_q == ST_RUN) && (cnt_q == C_CNT_LAST);

    case (state_q)
      ST_OFF:  s_ready = arst_n & en;
      ST_RUN:  s_ready = arst_n & en & slot;
      default: s_ready = 1'b0;
    endcase

    if (!en) begin
      // Abort at once: any partially sent word is dropped.
      state_d = ST_OFF;
      cnt_d   = '0;
      shift_d = '0;
      ser_d   = INV_MASK;
    end else if (s_ready) begin
      state_d    = ST_RUN;
      cnt_d      = '0;
      frame_d    = 1'b1;
      underrun_d = ~s_valid & (state_q == ST_RUN);
      for (int l = 0; l < NLANES; l++) begin
        word       = s_valid ? s_data[l*WIDTH +: WIDTH] : IDLE_WORD;
        ser_d[l]   = word[C_FIRST] ^ INV_MASK[l];
        shift_d[l] = shift_word(word);
      end
    end else begin
      state_d = ST_RUN;
      cnt_d   = cnt_q + 1'b1;
      for (int l = 0; l < NLANES; l++) begin
        ser_d[l]   = shift_q[l][C_FIRST] ^ INV_MASK[l];
        shift_d[l] = shift_word(shift_q[l]);
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= ST_OFF;
      cnt_q      <= '0;
      shift_q    <= '0;
      ser_q      <= INV_MASK;
      frame_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      ser_q      <= ser_d;
      frame_q    <= frame_d;
      underrun_q <= underrun_d;
    end
  end

  assign frame    = frame_q;
  assign underrun = underrun_q;

  generate
    for (genvar l = 0; l < NLANES; l++) begin : g_lane
      fpga_olvds_ser_obufds_tmds33 u_obuf (
        .d_i (ser_q[l]),
        .p_o (tx_p[l]),
        .n_o (tx_n[l])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/fpga_olvds_ser.md
Name: fpga_olvds_ser

Overview:
Parametrised multi-lane parallel-to-serial transmitter that feeds differential output pairs (TMDS/LVDS links such as DVI/HDMI or camera test-pattern out). It accepts one NLANES x WIDTH word per valid/ready handshake, shifts each lane out at one bit per clk, and inserts a programmable idle word on underrun. Each lane's registered serial bit drives one technology-library differential output buffer (TMDS_33, fast slew) inside the block.

Parameters:
NLANES, 4, number of serial lanes / differential pairs (>=1)
WIDTH, 10, bits per lane per word (>=2)
IDLE_WORD, 10'b1101010100, per-lane word sent when no data is available (TMDS ctrl 00)
LSB_FIRST, 1, 1 = bit 0 of each lane word transmitted first, 0 = bit WIDTH-1 first
INV_MASK, '0, NLANES bits; bit l=1 inverts lane l's serial bit (board P/N swap)

Ports:
clk  in  1  bit-rate clock; one serial bit per lane per cycle
arst_n  in  1  asynchronous active-low reset
en  in  1  transmitter enable, synchronous
s_data  in  NLANES*WIDTH  lane l word = s_data[l*WIDTH +: WIDTH]
s_valid  in  1  s_data valid
s_ready  out  1  block takes s_data this cycle when s_valid&s_ready
underrun  out  1  one-cycle pulse: IDLE_WORD loaded because s_valid was low at a load slot
frame  out  1  high in the cycle the first bit of a word is on the pads
tx_p  out  NLANES  differential positive outputs
tx_n  out  NLANES  differential negative outputs

Behaviour:
- Reset (arst_n=0, async): state=OFF, bit_cnt=0, shift regs=0, serial bits=INV_MASK (logic 0 after inversion), s_ready=0, underrun=0, frame=0. Release is sampled synchronously on clk.
- State OFF: s_ready=en. Serial bits held at 0^INV_MASK. en=1 -> load slot this cycle -> RUN.
- State RUN: bit_cnt counts 0..WIDTH-1 and wraps to 0; load slot when bit_cnt==WIDTH-1; s_ready = en & load slot (combinational from state/counter/en, never from s_valid).
- Load slot: s_valid=1 -> load s_data into all lane shift regs; s_valid=0 -> load IDLE_WORD into every lane, pulse underrun next cycle. Either way bit_cnt -> 0.
- Latency: word loaded on edge N; its first bit on tx_p/tx_n at cycle N+1 with frame=1; last bit at N+WIDTH. Back-to-back words have no gap bits.
- Bit order per LSB_FIRST; shift reg shifts every RUN cycle; serial output register = selected end bit XOR INV_MASK[l].
- tx_p[l]/tx_n[l] carry serial bit l / its complement via the buffer primitive; no combinational path from inputs to pads.
- en deasserted in RUN: abort immediately (mid-word allowed), next cycle state=OFF, outputs as in reset, partially sent word discarded, no underrun.
- en and load slot in same cycle with en=0: no load, no handshake.
- s_data not required stable outside handshake; underrun never asserted in OFF.
- All lanes share one counter: lanes are bit-aligned by construction.

Test Plan:
- Reset mid-word: RUN, assert arst_n=0 at bit 4 -> same cycle tx_p=INV_MASK, s_ready=0, frame=0; after release with en=1 first frame 1 cycle after the handshake.
- Single word NLANES=4, WIDTH=10, LSB_FIRST=1, lane0=10'h2AA: en=1, valid held -> handshake cycle N, tx_p[0] = 0,1,0,1,... at N+1..N+10, frame=1 only at N+1.
- Back-to-back 3 words, s_valid always 1 -> s_ready pulses exactly every 10 cycles, 30 contiguous bits, no underrun.
- Underrun: drop s_valid over one load slot -> next 10 bits each lane = IDLE_WORD 10'b1101010100, underrun high 1 cycle, then data resumes at following slot.
- INV_MASK=4'b0010, LSB_FIRST=0, word 10'h3FF all lanes -> lane1 tx_p=0 for 10 bits, others 1; tx_n complementary.
- en dropped at bit 5 -> next cycle OFF, tx_p=0^INV_MASK, s_ready low; en re-raised -> s_ready=1 same cycle, new word starts cleanly.
